// File: rtl/centroid_seq_if.sv
// Histogram bin stream into the centroid unit.
// One bin per valid/ready beat; last flags the final bin.
interface centroid_seq_if #(
  parameter int C_NB_HIST_VAL = 10
);
  logic                     bin_valid_i;
  logic                     bin_ready_o;
  logic [C_NB_HIST_VAL-1:0] bin_val_i;
  logic                     bin_last_i;

  modport master (
    output bin_valid_i,
    output bin_val_i,
    output bin_last_i,
    input  bin_ready_o
  );

  modport slave (
    input  bin_valid_i,
    input  bin_val_i,
    input  bin_last_i,
    output bin_ready_o
  );
endinterface

// File: rtl/centroid_seq.sv
// Weighted centroid of a column histogram, restoring divider.
// Optional EMA smoothing of the position: CENTROID_SMOOTH_EN.
module centroid_seq #(
  parameter int C_HIST_BINS     = 8,
  parameter int C_NB_HIST_VAL   = 10,
  parameter int C_NB_TOT        = 14,
  parameter int C_NB_FRAC       = 4,
  parameter int C_MIN_COLORPXLS = 100,
  parameter int C_NB_PROX       = 3,
  parameter int C_SMOOTH_SHIFT  = 2,
  localparam int NB_IDX  = $clog2(C_HIST_BINS),
  localparam int NB_POS  = NB_IDX + C_NB_FRAC,
  localparam int NB_WSUM = C_NB_TOT + NB_IDX
) (
  input  logic                   clk,
  input  logic                   rst,
  centroid_seq_if.slave          bin_if,
  output logic [NB_POS-1:0]      centroid_pos_o,
  output logic [C_HIST_BINS-1:0] centroid_bin_o,
  output logic                   detected_o,
  output logic [C_NB_PROX-1:0]   proximity_o,
  output logic                   new_centroid_o,
  output logic                   bin_err_o
);

  localparam int NB_DIV = C_NB_TOT + NB_POS;
  localparam int NB_CNT = $clog2(NB_POS + 1);
  localparam logic [NB_IDX:0] BINS = (NB_IDX+1)'(C_HIST_BINS);
  localparam logic [NB_IDX:0] LAST = BINS - 1'b1;
  localparam logic [NB_CNT-1:0] CNT_END = NB_CNT'(NB_POS - 1);

  typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

  state_t              state;
  logic [NB_IDX:0]     idx;
  logic [C_NB_TOT-1:0] tot;
  logic [NB_WSUM-1:0]  wsum;
  logic [NB_DIV-1:0]   rem;
  logic [NB_DIV-1:0]   dsr;
  logic [NB_POS-1:0]   quo;
  logic [NB_CNT-1:0]   cnt;

  logic                hs;
  logic                keep;
  logic [C_NB_TOT:0]   tot_sum;
  logic [C_NB_TOT-1:0] tot_nxt;
  logic [NB_WSUM-1:0]  wsum_nxt;
  logic [C_NB_TOT-1:0] tot_ld;
  logic [NB_WSUM-1:0]  wsum_ld;
  logic                ge;
  logic [NB_DIV-1:0]   dif;
  logic [NB_POS-1:0]   q_fin;
  logic                det;
  logic [NB_POS-1:0]   pos_nxt;

`ifdef CENTROID_SMOOTH_EN
  logic                hist;
  logic signed [NB_POS:0] sd;
  logic signed [NB_POS:0] sh;
`endif

  // MSB position of the total mapped onto the proximity scale
  function automatic logic [C_NB_PROX-1:0] prox_f(
    input logic [C_NB_TOT-1:0] t
  );
    int p;
    int v;
    p = -1;
    for (int k = 0; k < C_NB_TOT; k++)
      if (t[k]) p = k;
    v = p - (C_NB_TOT - (1 << C_NB_PROX));
    if (p < 0 || v < 0) v = 0;
    if (v > (1 << C_NB_PROX) - 1)
      v = (1 << C_NB_PROX) - 1;
    return C_NB_PROX'(v);
  endfunction

  // Accumulate step and one divider step
  always_comb begin
    hs = bin_if.bin_valid_i & bin_if.bin_ready_o;
    keep = hs & (idx < BINS);
    tot_sum = {1'b0, tot}
            + (C_NB_TOT+1)'(bin_if.bin_val_i);
    tot_nxt = tot_sum[C_NB_TOT] ? '1
            : tot_sum[C_NB_TOT-1:0];
    wsum_nxt = wsum
             + NB_WSUM'(idx[NB_IDX-1:0])
             * NB_WSUM'(bin_if.bin_val_i);
    tot_ld = keep ? tot_nxt : tot;
    wsum_ld = keep ? wsum_nxt : wsum;
    ge = rem >= dsr;
    dif = rem - dsr;
  end

  // Frame result, raw or smoothed
  always_comb begin
    q_fin = (tot == '0) ? '0 : quo;
    det = tot > C_NB_TOT'(C_MIN_COLORPXLS);
`ifdef CENTROID_SMOOTH_EN
    sd = $signed({1'b0, q_fin})
       - $signed({1'b0, centroid_pos_o});
    sh = sd >>> C_SMOOTH_SHIFT;
    if (!det)
      pos_nxt = '0;
    else if (!hist)
      pos_nxt = q_fin;
    else
      pos_nxt = centroid_pos_o + sh[NB_POS-1:0];
`else
    pos_nxt = det ? q_fin : '0;
`endif
  end

  // ACC -> DIV -> OUT sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACC;
      idx <= '0;
      tot <= '0;
      wsum <= '0;
      rem <= '0;
      dsr <= '0;
      quo <= '0;
      cnt <= '0;
      bin_if.bin_ready_o <= 1'b1;
      centroid_pos_o <= '0;
      centroid_bin_o <= '0;
      detected_o <= 1'b0;
      proximity_o <= '0;
      new_centroid_o <= 1'b0;
      bin_err_o <= 1'b0;
`ifdef CENTROID_SMOOTH_EN
      hist <= 1'b0;
`endif
    end else begin
      new_centroid_o <= 1'b0;
      bin_err_o <= 1'b0;
      unique case (state)
        ACC: begin
          if (hs) begin
            if (keep) begin
              tot <= tot_nxt;
              wsum <= wsum_nxt;
            end
            if (idx != BINS) idx <= idx + 1'b1;
            if (bin_if.bin_last_i) begin
              bin_err_o <= (idx != LAST);
              bin_if.bin_ready_o <= 1'b0;
              state <= DIV;
              cnt <= '0;
              quo <= '0;
              rem <= {wsum_ld, {C_NB_FRAC{1'b0}}};
              dsr <= {1'b0, tot_ld,
                      {(NB_POS-1){1'b0}}};
            end
          end
        end
        DIV: begin
          if (ge) rem <= dif;
          quo <= {quo[NB_POS-2:0], ge};
          dsr <= dsr >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_END) state <= OUT;
        end
        OUT: begin
          centroid_pos_o <= pos_nxt;
          centroid_bin_o <= det
            ? (C_HIST_BINS'(1)
               << pos_nxt[NB_POS-1:C_NB_FRAC])
            : '0;
          detected_o <= det;
          proximity_o <= prox_f(tot);
          new_centroid_o <= 1'b1;
`ifdef CENTROID_SMOOTH_EN
          hist <= det;
`endif
          tot <= '0;
          wsum <= '0;
          idx <= '0;
          bin_if.bin_ready_o <= 1'b1;
          state <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
